// File: rtl/isp_fifo_wconv_pkg.sv
// Shared ISP input-interface definitions: bus/pixel widths, lane-order
// constants and a constant-foldable log2 helper.
package isp_fifo_wconv_pkg;

   localparam int ISP_BUS_W = 64;
   localparam int ISP_PIX_W = 16;

   // Lane-order selectors for the wide-to-narrow unpacking
   localparam int LANE_MSB_FIRST = 0;
   localparam int LANE_LSB_FIRST = 1;

   // Ceiling log2, usable in parameter expressions
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/isp_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module isp_fifo_ram
   import isp_fifo_wconv_pkg::*;
#(
   parameter int DEPTH = 4096,
   parameter int WIDTH = ISP_BUS_W,
   parameter int AW    = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port: store on accepted write only
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/isp_fifo_wconv.sv
// Wide-in / narrow-out first-word-fall-through FIFO for the ISP input
// interface. Each stored bus word is presented as RATIO narrow samples.
module isp_fifo_wconv
   import isp_fifo_wconv_pkg::*;
#(
   parameter int WDATA_WIDTH  = ISP_BUS_W,
   parameter int RDATA_WIDTH  = ISP_PIX_W,
   parameter int DEPTH        = 4096,
   parameter int LSB_FIRST    = LANE_LSB_FIRST,
   parameter int AFULL_THRESH = DEPTH - 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush,
   input  logic                        wr_en,
   input  logic [WDATA_WIDTH-1:0]      wr_data,
   output logic                        full_n,
   output logic                        almost_full,
   input  logic                        rd_en,
   output logic [RDATA_WIDTH-1:0]      rd_data,
   output logic                        empty_n,
   output logic [clog2(DEPTH):0]       level
);

   localparam int RATIO = WDATA_WIDTH / RDATA_WIDTH;
   localparam int AW    = clog2(DEPTH);
   localparam int LW    = (RATIO > 1) ? clog2(RATIO) : 1;
   localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(DEPTH);
   localparam logic [LW-1:0] LANE_LAST  = LW'(RATIO - 1);

   if ((WDATA_WIDTH % RDATA_WIDTH) != 0) begin : g_bad_ratio
      $error("isp_fifo_wconv: WDATA_WIDTH must be a multiple of RDATA_WIDTH");
   end
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("isp_fifo_wconv: DEPTH must be a power of two, at least 2");
   end

   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic [LW-1:0]          lane;
   logic                   clear;
   logic                   wr_acc;
   logic                   pop;
   logic                   word_done;
   logic [WDATA_WIDTH-1:0] word;
   logic [RDATA_WIDTH-1:0] lanes [RATIO];
   logic [LW-1:0]          sel;

   // Flush acts like reset on the control state; memory is left untouched
   assign clear     = !rst_n || flush;
   assign wr_acc    = !clear && wr_en && full_n;
   assign pop       = !clear && rd_en && empty_n;
   // With RATIO==1 the lane counter stays at 0, so every pop releases a word
   assign word_done = pop && (lane == LANE_LAST);

   assign full_n      = (level != LEVEL_FULL);
   assign empty_n     = (level != '0);
   assign almost_full = (int'(level) >= AFULL_THRESH);

   isp_fifo_ram #(
      .DEPTH (DEPTH),
      .WIDTH (WDATA_WIDTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr),
      .wdata (wr_data),
      .raddr (rd_ptr),
      .rdata (word)
   );

   // Pointers, lane counter and fill level
   always_ff @(posedge clk) begin
      if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         lane   <= '0;
         level  <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            if (word_done) begin
               lane   <= '0;
               rd_ptr <= rd_ptr + AW'(1);
            end else begin
               lane   <= lane + LW'(1);
            end
         end
         case ({wr_acc, word_done})
            2'b10:   level <= level + (AW + 1)'(1);
            2'b01:   level <= level - (AW + 1)'(1);
            default: level <= level;
         endcase
      end
   end

   for (genvar g = 0; g < RATIO; g++) begin : g_lane
      assign lanes[g] = word[g*RDATA_WIDTH +: RDATA_WIDTH];
   end

   // Lane select honouring the configured order; output forced to 0 when empty
   always_comb begin
      sel     = (LSB_FIRST != 0) ? lane : (LANE_LAST - lane);
      rd_data = empty_n ? lanes[sel] : '0;
   end

endmodule
